// File: rtl/formula_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : formula_sweep_checker
// Function : Sweeps every x assignment of a quantified formula, fetches a
//            candidate i per x over valid/ready, and checks the formula output.
// Options  : FORMULA_SWEEP_STOP_ON_FAIL_EN - end the sweep at the first failure
// Revision : 1.0 - initial release
// ============================================================================
module formula_sweep_checker #(
  parameter int NX = 4,
  parameter int NI = 9,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [NX-1:0] x_vec,
  output logic          cand_ready,
  input  logic          cand_valid,
  input  logic [NI-1:0] cand_i,
  output logic [NI-1:0] i_vec,
  input  logic          f_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] fail_count,
  output logic          cex_valid,
  output logic [NX-1:0] cex_x,
  output logic [NI-1:0] cex_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef FORMULA_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic [NX-1:0] x_vec_q, x_vec_d;
  logic [NI-1:0] i_vec_q, i_vec_d;
  logic [CW-1:0] fail_q, fail_d;
  logic          cex_valid_q, cex_valid_d;
  logic [NX-1:0] cex_x_q, cex_x_d;
  logic [NI-1:0] cex_i_q, cex_i_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic start_acc;
  logic handshake;
  logic eval_act;
  logic eval_fail;
  logic abort_act;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort outranks every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (abort)           state_d = S_IDLE;
        else if (cand_valid) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (abort)                          state_d = S_IDLE;
        else if (STOP_ON_FAIL && eval_fail) state_d = S_DONE;
        else if (&x_vec_q)                  state_d = S_DONE;
        else                                state_d = S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    cand_ready = (state_q == S_REQ);
    abort_act  = abort && ((state_q == S_REQ) || (state_q == S_EVAL));
    start_acc  = (state_q == S_IDLE) && start;
    handshake  = cand_ready && cand_valid && !abort;
    eval_act   = (state_q == S_EVAL) && !abort;
    eval_fail  = eval_act && !f_out;
  end

  // Datapath next-state
  always_comb begin
    x_vec_d     = x_vec_q;
    i_vec_d     = i_vec_q;
    fail_d      = fail_q;
    cex_valid_d = cex_valid_q;
    cex_x_d     = cex_x_q;
    cex_i_d     = cex_i_q;
    busy_d      = busy_q;
    pass_d      = pass_q;
    done_d      = 1'b0;

    if (start_acc) begin
      x_vec_d     = '0;
      i_vec_d     = '0;
      fail_d      = '0;
      pass_d      = 1'b0;
      cex_valid_d = 1'b0;
      cex_x_d     = '0;
      cex_i_d     = '0;
      busy_d      = 1'b1;
    end

    if (handshake) i_vec_d = cand_i;

    if (eval_fail) begin
      if (!(&fail_q)) fail_d = fail_q + CW'(1);
      if (!cex_valid_q) begin
        cex_valid_d = 1'b1;
        cex_x_d     = x_vec_q;
        cex_i_d     = i_vec_q;
      end
    end

    // x only advances on the EVAL->REQ edge, so the formula sees it stable
    if (eval_act && (state_d == S_REQ)) x_vec_d = x_vec_q + NX'(1);

    if (abort_act) busy_d = 1'b0;

    // Final counter update has landed by the time DONE is reached
    if (state_q == S_DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      pass_d = (fail_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_vec_q     <= '0;
      i_vec_q     <= '0;
      fail_q      <= '0;
      cex_valid_q <= 1'b0;
      cex_x_q     <= '0;
      cex_i_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      x_vec_q     <= x_vec_d;
      i_vec_q     <= i_vec_d;
      fail_q      <= fail_d;
      cex_valid_q <= cex_valid_d;
      cex_x_q     <= cex_x_d;
      cex_i_q     <= cex_i_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign x_vec      = x_vec_q;
  assign i_vec      = i_vec_q;
  assign fail_count = fail_q;
  assign cex_valid  = cex_valid_q;
  assign cex_x      = cex_x_q;
  assign cex_i      = cex_i_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_formula_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_formula_sweep_checker
// Function : Randomised self-checking bench for formula_sweep_checker with a
//            behavioural formula, candidate responder and sweep model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_formula_sweep_checker;
  localparam int NX = 4;
  localparam int NI = 9;
  localparam int CW = 16;
  localparam int NV = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, cand_valid, f_out;
  logic [NI-1:0] cand_i;
  logic [NX-1:0] x_vec, cex_x;
  logic [NI-1:0] i_vec, cex_i;
  logic          cand_ready, busy, done, pass, cex_valid;
  logic [CW-1:0] fail_count;

  logic          s_start;
  logic          s_one = 1'b1;
  logic          s_zero = 1'b0;
  logic [NI-1:0] s_cand = '0;
  logic [NX-1:0] s_x, s_cexx;
  logic [NI-1:0] s_i, s_cexi;
  logic          s_ready, s_busy, s_done, s_pass, s_cexv;
  logic [1:0]    s_fc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NV-1:0] fail_tbl;
  logic [NI-1:0] cand_tbl [NV];
  int            delay_mode;
  int            req_cyc = 0;
  int            cur_delay = 0;
  int            dq[$];
  logic [NX-1:0] hs_q[$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            unstable = 0;
  logic          prev_ready = 1'b0;
  logic [NX-1:0] prev_x = '0;

  always #5 clk = ~clk;

  formula_sweep_checker #(.NX(NX), .NI(NI), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_vec(x_vec), .cand_ready(cand_ready), .cand_valid(cand_valid),
    .cand_i(cand_i), .i_vec(i_vec), .f_out(f_out), .busy(busy),
    .done(done), .pass(pass), .fail_count(fail_count),
    .cex_valid(cex_valid), .cex_x(cex_x), .cex_i(cex_i)
  );

  formula_sweep_checker #(.NX(NX), .NI(NI), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_zero),
    .x_vec(s_x), .cand_ready(s_ready), .cand_valid(s_one),
    .cand_i(s_cand), .i_vec(s_i), .f_out(s_zero), .busy(s_busy),
    .done(s_done), .pass(s_pass), .fail_count(s_fc),
    .cex_valid(s_cexv), .cex_x(s_cexx), .cex_i(s_cexi)
  );

  // Formula: true unless x is in the failure set; a wrong i also makes it false
  assign cand_i = cand_tbl[x_vec];
  assign f_out  = (i_vec == cand_tbl[x_vec]) ? ~fail_tbl[x_vec] : 1'b0;

  // Candidate unit: answers after a chosen delay; random noise outside REQ
  always @(negedge clk) begin
    if (cand_ready) begin
      if (req_cyc == 0) cur_delay = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
      cand_valid = (req_cyc >= cur_delay);
      if (req_cyc == cur_delay) dq.push_back(cur_delay);
      req_cyc++;
    end else begin
      req_cyc    = 0;
      cand_valid = 1'($urandom_range(0, 1));
    end
    if (done) done_cnt++;
    if (cand_ready && prev_ready && (x_vec != prev_x)) unstable++;
    prev_ready = cand_ready;
    prev_x     = x_vec;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && cand_valid && cand_ready) hs_q.push_back(x_vec);
  end

  // Reference: which vectors get evaluated and what the verdict must be
  task automatic model(input logic [NV-1:0] ft, input int upto, output int cnt,
                       output bit cv, output int cx, output int ci, output int nvec);
    cnt = 0; cv = 1'b0; cx = 0; ci = 0; nvec = 0;
    for (int x = 0; x < upto; x++) begin
      nvec++;
      if (ft[x]) begin
        cnt++;
        if (!cv) begin cv = 1'b1; cx = x; ci = int'(cand_tbl[x]); end
`ifdef FORMULA_SWEEP_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  task automatic do_sweep(output int lat, output bit to);
    int e0;
    hs_q.delete();
    dq.delete();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk) start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    lat = cyc - e0;
  endtask

  function automatic int first_bad(input int n);
    if (hs_q.size() != n) return 999;
    for (int k = 0; k < n; k++) if (hs_q[k] != NX'(k)) return k;
    return -1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({x_vec, i_vec, cand_ready, busy, done, pass, fail_count, cex_valid, cex_x, cex_i} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero x=%h i=%h busy=%b fc=%h, want all 0", x_vec, i_vec, busy, fail_count);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cand_ready, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: ready/busy/done=%b want 000", {cand_ready, busy, done});
    end
  endtask

  task automatic test_pass_sweep;
    int lat; bit to;
    fail_tbl = '0; delay_mode = 0;
    for (int k = 0; k < NV; k++) cand_tbl[k] = NI'($urandom);
    do_sweep(lat, to);
    n_checks++;
    if (to || lat != 2 * NV + 1) begin n_fail++; $display("FAIL pass_latency: got %0d timeout=%0d want %0d", lat, to, 2 * NV + 1); end
    n_checks++;
    if ({pass, busy, cex_valid} !== 3'b100 || fail_count !== '0) begin
      n_fail++; $display("FAIL pass_result: pass/busy/cexv=%b fc=%0d want 100 fc=0", {pass, busy, cex_valid}, fail_count);
    end
    n_checks++;
    if (first_bad(NV) != -1) begin n_fail++; $display("FAIL pass_order: first bad handshake %0d of %0d, want 16 in order", first_bad(NV), hs_q.size()); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin n_fail++; $display("FAIL pass_hold: done=%b pass=%b want done=0 pass=1", done, pass); end
  endtask

  task automatic test_fail_sweep;
    int lat, cnt, cx, ci, nv; bit to, cv;
    fail_tbl = '0; fail_tbl[5] = 1'b1; fail_tbl[12] = 1'b1; delay_mode = 0;
    for (int k = 0; k < NV; k++) cand_tbl[k] = NI'(k + 3);
    model(fail_tbl, NV, cnt, cv, cx, ci, nv);
    do_sweep(lat, to);
    n_checks++;
    if (to || pass !== 1'b0 || fail_count !== CW'(cnt)) begin
      n_fail++; $display("FAIL fail_count: got fc=%0d pass=%b timeout=%0d want fc=%0d pass=0", fail_count, pass, to, cnt);
    end
    n_checks++;
    if (cex_valid !== 1'b1 || cex_x !== NX'(cx) || cex_i !== NI'(ci)) begin
      n_fail++; $display("FAIL fail_cex: got v=%b x=%0d i=%0d want v=1 x=%0d i=%0d", cex_valid, cex_x, cex_i, cx, ci);
    end
    n_checks++;
    if (x_vec !== NX'(nv - 1) || first_bad(nv) != -1) begin
      n_fail++; $display("FAIL fail_last_x: got x=%0d handshakes=%0d want x=%0d handshakes=%0d", x_vec, hs_q.size(), nv - 1, nv);
    end
  endtask

  task automatic test_delayed;
    int lat; bit to;
    fail_tbl = '0; delay_mode = 3; unstable = 0;
    do_sweep(lat, to);
    n_checks++;
    if (to || lat != NV * 5 + 1) begin n_fail++; $display("FAIL delayed_latency: got %0d timeout=%0d want %0d", lat, to, NV * 5 + 1); end
    n_checks++;
    if (first_bad(NV) != -1 || unstable != 0) begin
      n_fail++; $display("FAIL delayed_order: bad=%0d unstable=%0d want -1 and 0", first_bad(NV), unstable);
    end
    n_checks++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL delayed_pass: got %b want 1", pass); end
  endtask

  task automatic test_random;
    int lat, cnt, cx, ci, nv, exp_lat; bit to, cv;
    for (int it = 0; it < 6; it++) begin
      fail_tbl   = ($urandom_range(0, 2) == 0) ? '0 : NV'($urandom);
      delay_mode = (it % 2) ? -1 : int'($urandom_range(0, 2));
      unstable   = 0;
      for (int k = 0; k < NV; k++) cand_tbl[k] = NI'($urandom);
      model(fail_tbl, NV, cnt, cv, cx, ci, nv);
      do_sweep(lat, to);
      exp_lat = 2 * nv + 1;
      foreach (dq[k]) exp_lat += dq[k];
      n_checks++;
      if (to || lat != exp_lat || unstable != 0) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d timeout=%0d unstable=%0d want %0d", it, lat, to, unstable, exp_lat);
      end
      n_checks++;
      if (pass !== (cnt == 0) || fail_count !== CW'(cnt) || cex_valid !== cv) begin
        n_fail++; $display("FAIL rand_result[%0d]: got pass=%b fc=%0d cexv=%b want pass=%0d fc=%0d cexv=%0d", it, pass, fail_count, cex_valid, cnt == 0, cnt, cv);
      end
      n_checks++;
      if (cv && (cex_x !== NX'(cx) || cex_i !== NI'(ci))) begin
        n_fail++; $display("FAIL rand_cex[%0d]: got x=%0d i=%0d want x=%0d i=%0d", it, cex_x, cex_i, cx, ci);
      end
      n_checks++;
      if (first_bad(nv) != -1) begin n_fail++; $display("FAIL rand_order[%0d]: bad=%0d size=%0d want %0d in order", it, first_bad(nv), hs_q.size(), nv); end
    end
  endtask

  task automatic test_reset_mid;
    int lat; bit to, hit;
    fail_tbl = '0; delay_mode = 0; hit = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (x_vec == 4'd7) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!hit || {x_vec, i_vec, cand_ready, busy, done, pass, fail_count, cex_valid, cex_x, cex_i} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: reached7=%0d x=%0d busy=%b ready=%b want all 0", hit, x_vec, busy, cand_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_sweep(lat, to);
    n_checks++;
    if (to || lat != 2 * NV + 1 || first_bad(NV) != -1 || pass !== 1'b1) begin
      n_fail++; $display("FAIL midreset_restart: lat=%0d timeout=%0d bad=%0d pass=%b want %0d,-1,1", lat, to, first_bad(NV), pass, 2 * NV + 1);
    end
  endtask

  task automatic test_abort;
    int cnt, cx, ci, nv, d0; bit cv, poked, hit;
    fail_tbl = '0;
`ifndef FORMULA_SWEEP_STOP_ON_FAIL_EN
    fail_tbl[6] = 1'b1;
`endif
    fail_tbl[12] = 1'b1;
    delay_mode = 0; poked = 1'b0; hit = 1'b0;
    model(fail_tbl, 9, cnt, cv, cx, ci, nv);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    d0 = done_cnt;
    for (int c = 0; c < 200; c++) begin
      if (cand_ready && x_vec == 4'd9) begin hit = 1'b1; break; end
      if (cand_ready && x_vec == 4'd4 && !poked) begin
        poked = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (x_vec !== 4'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL start_while_busy: x=%0d busy=%b want x=4 busy=1", x_vec, busy); end
        @(negedge clk) start = 1'b0;
      end else @(negedge clk);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (!hit || busy !== 1'b0 || cand_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: reached9=%0d busy=%b ready=%b want 1,0,0", hit, busy, cand_ready);
    end
    @(negedge clk) abort = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || pass !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: done pulses=%0d pass=%b busy=%b want 0,0,0", done_cnt - d0, pass, busy);
    end
    n_checks++;
    if (fail_count !== CW'(cnt) || cex_valid !== cv || (cv && cex_x !== NX'(cx))) begin
      n_fail++; $display("FAIL abort_partial: fc=%0d cexv=%b cexx=%0d want fc=%0d cexv=%0d cexx=%0d", fail_count, cex_valid, cex_x, cnt, cv, cx);
    end
  endtask

  task automatic test_saturation;
    bit to;
    logic [1:0] exp_fc;
`ifdef FORMULA_SWEEP_STOP_ON_FAIL_EN
    exp_fc = 2'd1;
`else
    exp_fc = 2'd3;
`endif
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (s_done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    n_checks++;
    if (to || s_fc !== exp_fc || s_pass !== 1'b0) begin
      n_fail++; $display("FAIL sat_count: fc=%0d pass=%b timeout=%0d want fc=%0d pass=0", s_fc, s_pass, to, exp_fc);
    end
    n_checks++;
    if (s_cexv !== 1'b1 || s_cexx !== '0) begin n_fail++; $display("FAIL sat_cex: v=%b x=%0d want v=1 x=0", s_cexv, s_cexx); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_start = 1'b0;
    cand_valid = 1'b0; delay_mode = 0; fail_tbl = '0;
    for (int k = 0; k < NV; k++) cand_tbl[k] = '0;
    test_reset;
    test_pass_sweep;
    test_fail_sweep;
    test_delayed;
    test_random;
    test_reset_mid;
    test_abort;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
